// File: rtl/fpu_req_sched_pkg.sv
// Shared widths and operation codes for the fpu request scheduler and its clients.
package fpu_req_sched_pkg;

  localparam int MODE_WIDTH = 2;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [MODE_WIDTH-1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_MUL = 2'd2,
    MODE_DIV = 2'd3
  } fpu_mode_e;

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO with count-based full/empty. The head output reads zero while empty.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module fpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_req_sched.sv
// Issue/collect stage in front of a fixed-latency fpu: request FIFO, credit-gated issue,
// in-flight {valid,tag} pipe matching the fpu latency, and a response FIFO.
module fpu_req_sched
  import fpu_req_sched_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int FPU_LAT   = 1,
  parameter int TAG_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [MODE_WIDTH-1:0] req_mode_i,
  input  logic [DATA_WIDTH-1:0] req_in1_i,
  input  logic [DATA_WIDTH-1:0] req_in2_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic [MODE_WIDTH-1:0] fpu_mode_o,
  output logic [DATA_WIDTH-1:0] fpu_in1_o,
  output logic [DATA_WIDTH-1:0] fpu_in2_o,
  input  logic [DATA_WIDTH-1:0] fpu_out_i,
  input  logic                  fpu_overflow_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_overflow_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic                  busy_o
);

  localparam int REQ_W  = MODE_WIDTH + 2 * DATA_WIDTH + TAG_WIDTH;
  localparam int RSP_W  = DATA_WIDTH + 1 + TAG_WIDTH;
  localparam int CW     = $clog2(RSP_DEPTH + 1);
  localparam int REQ_CW = $clog2(REQ_DEPTH + 1);
  localparam logic [CW:0] CREDIT_LIM = (CW + 1)'(RSP_DEPTH);

  logic [REQ_W-1:0]      req_head;
  logic                  req_full;
  logic                  req_empty;
  logic [REQ_CW-1:0]     req_cnt;
  logic [MODE_WIDTH-1:0] head_mode;
  logic [DATA_WIDTH-1:0] head_in1;
  logic [DATA_WIDTH-1:0] head_in2;
  logic [TAG_WIDTH-1:0]  head_tag;

  logic [RSP_W-1:0]      rsp_head;
  logic                  rsp_full;
  logic                  rsp_empty;
  logic [CW-1:0]         rsp_cnt;

  logic [FPU_LAT-1:0]    vld_p;
  logic [TAG_WIDTH-1:0]  tag_p [FPU_LAT];
  logic [CW-1:0]         inflight_cnt;
  logic                  issue;
  logic                  cap;

  assign req_ready_o = ~req_full;

  fpu_sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid_i & req_ready_o),
    .push_data ({req_mode_i, req_in1_i, req_in2_i, req_tag_i}),
    .pop       (issue),
    .head      (req_head),
    .full      (req_full),
    .empty     (req_empty),
    .count     (req_cnt)
  );

  assign {head_mode, head_in1, head_in2, head_tag} = req_head;

  // Responses already queued plus results still in the fpu may never exceed the
  // response FIFO depth, so every capture is guaranteed a free slot.
  assign issue = ~req_empty & (({1'b0, inflight_cnt} + {1'b0, rsp_cnt}) < CREDIT_LIM);

  assign fpu_mode_o = issue ? head_mode : '0;
  assign fpu_in1_o  = issue ? head_in1  : '0;
  assign fpu_in2_o  = issue ? head_in2  : '0;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < FPU_LAT; i++) inflight_cnt = inflight_cnt + CW'(vld_p[i]);
  end

  // Stage boundary: in-flight valid pipe, one stage per fpu latency cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < FPU_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= head_tag;
    for (int i = 1; i < FPU_LAT; i++) tag_p[i] <= tag_p[i-1];
  end

  assign cap = vld_p[FPU_LAT-1];

  fpu_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap),
    .push_data ({fpu_out_i, fpu_overflow_i, tag_p[FPU_LAT-1]}),
    .pop       (rsp_ready_i),
    .head      (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .count     (rsp_cnt)
  );

  assign rsp_valid_o = ~rsp_empty;
  assign {rsp_data_o, rsp_overflow_o, rsp_tag_o} = rsp_head;

  assign busy_o = ~req_empty | (inflight_cnt != '0) | ~rsp_empty;

  cap_into_full: assert property (@(posedge clk) disable iff (!rst)
    !(cap && rsp_full && !rsp_ready_i));

endmodule
